// File: rtl/smachine_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM sequencer for the S-machine datapath.
// Owns the memory handshake and drives register/PC strobes; traps illegal opcodes and memory timeouts.
module smachine_seq #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned RET_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [15:0]      opCode,
  input  logic [2:0]       ZNC,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [1:0]       src_sel,
  output logic             a_we,
  output logic             b_we,
  output logic             znc_we,
  output logic             halted,
  output logic             fault,
  output logic [RET_W-1:0] retired
);

  localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] SRC_ALU  = 2'd0;
  localparam logic [1:0] SRC_CMP  = 2'd1;
  localparam logic [1:0] SRC_LOAD = 2'd2;
  localparam logic [1:0] SRC_HOLD = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT, S_FAULT
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [RET_W-1:0]  ret_q, ret_d;

  logic [3:0] cls;
  logic       dest_b;
  logic       taken;
  logic       to_hit;
  logic       unused_opcode;

  assign cls           = opCode[15:12];
  assign dest_b        = opCode[11];
  assign taken         = |(opCode[11:9] & ZNC);
  assign to_hit        = (to_q == TO_W'(MEM_TIMEOUT - 1));
  assign unused_opcode = ^opCode[8:0];
  assign retired       = ret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      to_q    <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      ret_q   <= ret_d;
    end
  end

  // Next state plus strobes; strobes depend on mem_ack so they land in the ack cycle.
  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    ret_d   = ret_q;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_we   = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    src_sel = SRC_HOLD;
    a_we    = 1'b0;
    b_we    = 1'b0;
    znc_we  = 1'b0;
    halted  = 1'b0;
    fault   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          to_d    = '0;
        end
      end

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end else if (to_hit) begin
          state_d = S_FAULT;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      S_DECODE: begin
        case (cls)
          4'hC, 4'hD, 4'hE: state_d = S_FAULT;
          4'hF:             state_d = S_HALT;
          4'h9, 4'hA: begin
            state_d = S_MEM;
            to_d    = '0;
          end
          default:          state_d = S_EXEC;
        endcase
      end

      S_EXEC: begin
        ret_d = ret_q + RET_W'(1);
        case (cls)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
            src_sel = SRC_ALU;
            a_we    = ~dest_b;
            b_we    = dest_b;
            znc_we  = 1'b1;
          end
          4'h8: begin
            src_sel = SRC_CMP;
            znc_we  = 1'b1;
          end
          4'hB:    pc_load = taken;
          default: ;
        endcase
        to_d    = '0;
        state_d = run ? S_FETCH : S_IDLE;
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls == 4'hA);
        if (mem_ack) begin
          ret_d = ret_q + RET_W'(1);
          if (cls == 4'h9) begin
            src_sel = SRC_LOAD;
            a_we    = ~dest_b;
            b_we    = dest_b;
          end
          to_d    = '0;
          state_d = run ? S_FETCH : S_IDLE;
        end else if (to_hit) begin
          state_d = S_FAULT;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: state_d = S_FAULT;
    endcase
  end

endmodule

// File: tb/tb_smachine_seq.sv
// Scoreboard bench for smachine_seq: stimulus queues expected strobe events, a monitor checks them.
module tb_smachine_seq;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [15:0] opCode;
  logic [2:0]  ZNC;
  logic        mem_ack;
  logic        mem_req, mem_we, ir_we, pc_inc, pc_load;
  logic [1:0]  src_sel;
  logic        a_we, b_we, znc_we, halted, fault;
  logic [15:0] retired;

  smachine_seq #(.MEM_TIMEOUT(16), .RET_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opCode(opCode), .ZNC(ZNC),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
    .pc_inc(pc_inc), .pc_load(pc_load), .src_sel(src_sel), .a_we(a_we),
    .b_we(b_we), .znc_we(znc_we), .halted(halted), .fault(fault),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ir;
    logic        pci;
    logic        pcl;
    logic        a;
    logic        b;
    logic        znc;
    logic [1:0]  src;
    logic        mw;
    logic [15:0] ret;
  } ev_t;

  int  total = 0;
  int  bad   = 0;
  ev_t exp_q[$];

  int  dq[$];
  int  cur, wcnt, last_len;
  bit  have, stray, acc_or, acc_and, last_or, last_and;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] outs();
    return {mem_req, mem_we, ir_we, pc_inc, pc_load, a_we, b_we, znc_we,
            halted, fault, src_sel};
  endfunction

  function automatic ev_t ev_fetch(input int r);
    return '{ir:1'b1, pci:1'b1, pcl:1'b0, a:1'b0, b:1'b0, znc:1'b0, src:2'd3, mw:1'b0, ret:16'(r)};
  endfunction

  function automatic ev_t ev_wr(input logic a, input logic b, input logic z,
                                input logic [1:0] s, input int r);
    return '{ir:1'b0, pci:1'b0, pcl:1'b0, a:a, b:b, znc:z, src:s, mw:1'b0, ret:16'(r)};
  endfunction

  function automatic ev_t ev_br(input int r);
    return '{ir:1'b0, pci:1'b0, pcl:1'b1, a:1'b0, b:1'b0, znc:1'b0, src:2'd3, mw:1'b0, ret:16'(r)};
  endfunction

  // Memory responder: each new request pops an ack delay (-1 = never ack).
  initial begin
    mem_ack = 1'b0; have = 0; stray = 0; wcnt = 0; cur = 0;
    last_len = 0; last_or = 0; last_and = 0; acc_or = 0; acc_and = 1;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!rst_n) begin
        have = 0;
      end else if (mem_req) begin
        if (!have) begin
          cur = (dq.size() > 0) ? dq.pop_front() : 0;
          have = 1; wcnt = 0; acc_or = 0; acc_and = 1;
        end
        acc_or  = acc_or | mem_we;
        acc_and = acc_and & mem_we;
        if (cur >= 0 && wcnt == cur) begin
          mem_ack  = 1'b1;
          have     = 0;
          last_len = wcnt + 1;
          last_or  = acc_or;
          last_and = acc_and;
        end else begin
          wcnt++;
        end
      end else if (stray) begin
        mem_ack = 1'b1;
        stray   = 0;
      end
    end
  end

  // Monitor: any strobe cycle is an output event matched against the scoreboard.
  initial begin
    ev_t got;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && (ir_we | pc_inc | pc_load | a_we | b_we | znc_we)) begin
        got = '{ir:ir_we, pci:pc_inc, pcl:pc_load, a:a_we, b:b_we, znc:znc_we,
                src:src_sel, mw:mem_we, ret:retired};
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event actual=%0h required=none t=%0t", got, $time);
        end else begin
          check("event", 32'(got), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic issue(input logic [15:0] op, input logic [2:0] z, input int fd, input int md);
    @(negedge clk);
    opCode = op; ZNC = z; run = 1'b1;
    dq.push_back(fd);
    if (md >= -1) dq.push_back(md);
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_ret(input int exp);
    int n = 0;
    while (retired !== 16'(exp) && n < 64) begin
      @(negedge clk); #1; n++;
    end
    check("retired", 32'(retired), 32'(exp));
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic wait_flag(input string name, input bit want_fault);
    int n = 0;
    while (!(want_fault ? fault : halted) && n < 64) begin
      @(negedge clk); #1; n++;
    end
    check(name, 32'(want_fault ? fault : halted), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0;
    #1;
    check("reset_outs", 32'(outs()), 32'h003);
    check("reset_retired", 32'(retired), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; run = 1'b0; opCode = 16'h0000; ZNC = 3'b000;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outs", 32'(outs()), 32'h003);
    check("reset_retired", 32'(retired), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU to A, ALU to B, CMP
    exp_q.push_back(ev_fetch(0)); exp_q.push_back(ev_wr(1, 0, 1, 2'd0, 0));
    issue(16'h1000, 3'b000, 0, -2); wait_ret(1);
    check("idle_outs", 32'(outs()), 32'h003);
    exp_q.push_back(ev_fetch(1)); exp_q.push_back(ev_wr(0, 1, 1, 2'd0, 1));
    issue(16'h3800, 3'b000, 0, -2); wait_ret(2);
    exp_q.push_back(ev_fetch(2)); exp_q.push_back(ev_wr(0, 0, 1, 2'd1, 2));
    issue(16'h8000, 3'b000, 0, -2); wait_ret(3);

    // LOAD to B with ack in the 4th MEM cycle
    exp_q.push_back(ev_fetch(3)); exp_q.push_back(ev_wr(0, 1, 0, 2'd2, 3));
    issue(16'h9800, 3'b000, 0, 3); wait_ret(4);
    check("load_req_len", 32'(last_len), 32'd4);
    check("load_mem_we", 32'(last_or), 32'd0);

    // Branches: mask N taken/not taken, mask C taken
    exp_q.push_back(ev_fetch(4)); exp_q.push_back(ev_br(4));
    issue(16'hB400, 3'b010, 0, -2); wait_ret(5);
    exp_q.push_back(ev_fetch(5));
    issue(16'hB400, 3'b101, 0, -2); wait_ret(6);
    exp_q.push_back(ev_fetch(6)); exp_q.push_back(ev_br(6));
    issue(16'hB200, 3'b101, 0, -2); wait_ret(7);

    // NOP with ack on the last cycle before timeout: ack wins
    exp_q.push_back(ev_fetch(7));
    issue(16'h0000, 3'b000, 15, -2); wait_ret(8);
    check("late_ack_len", 32'(last_len), 32'd16);
    check("late_ack_nofault", 32'(fault), 32'd0);

    // Ack with no request pending is ignored
    stray = 1;
    repeat (3) @(negedge clk);
    #1;
    check("stray_outs", 32'(outs()), 32'h003);
    check("stray_retired", 32'(retired), 32'd8);

    // STORE with run dropped during MEM
    exp_q.push_back(ev_fetch(8));
    dq.push_back(0); dq.push_back(5);
    @(negedge clk);
    opCode = 16'hA000; run = 1'b1;
    cnt = 0;
    do begin @(negedge clk); #1; cnt++; end while (!ir_we && cnt < 20);
    @(negedge clk);
    @(negedge clk);
    run = 1'b0;
    #1;
    check("store_req_we", 32'({mem_req, mem_we}), 32'h3);
    wait_ret(9);
    check("store_req_len", 32'(last_len), 32'd6);
    check("store_we_held", 32'(last_and), 32'd1);
    check("store_idle", 32'(outs()), 32'h003);
    exp_q.push_back(ev_fetch(9));
    @(negedge clk);
    opCode = 16'h0000; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    #1;
    check("restart_req", 32'(mem_req), 32'd1);
    wait_ret(10);

    // Illegal opcode
    exp_q.push_back(ev_fetch(10));
    issue(16'hC000, 3'b000, 0, -2);
    wait_flag("illegal_fault", 1'b1);
    check("illegal_outs", 32'(outs()), 32'h007);
    check("illegal_retired", 32'(retired), 32'd10);
    do_reset();

    // FETCH timeout
    @(negedge clk);
    opCode = 16'h1000; run = 1'b1; dq.push_back(-1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      run = 1'b0;
      #1;
      if (fault) break;
      if (mem_req) cnt++;
    end
    check("timeout_req_cycles", 32'(cnt), 32'd16);
    check("timeout_outs", 32'(outs()), 32'h007);
    repeat (5) @(negedge clk);
    #1;
    check("fault_sticky", 32'(outs()), 32'h007);
    do_reset();

    // HALT: no further requests even with run held
    exp_q.push_back(ev_fetch(0));
    @(negedge clk);
    opCode = 16'hF000; run = 1'b1;
    wait_flag("halt_reached", 1'b0);
    check("halt_outs", 32'(outs()), 32'h00B);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (mem_req) cnt++;
    end
    check("halt_no_req", 32'(cnt), 32'd0);
    check("halt_retired", 32'(retired), 32'd0);
    do_reset();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
